// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: 8x8 multiply-accumulate sequenced over a shared 2x2 multiplier, sixteen digit products per operation
module mac_seq_ctrl #(
    parameter int ACC_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clr_acc,
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    output logic [1:0]       mult_a,
    output logic [1:0]       mult_b,
    input  logic [3:0]       mult_p,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] acc_out,
    output logic             ovf
);
    typedef enum logic [1:0] {IDLE, MUL, ACC, DONE} state_t;
    state_t             state_q, state_d;
    logic [7:0]         a_q, a_d, b_q, b_d;
    logic [15:0]        prod_q, prod_d, pp;
    logic [3:0]         idx_q, idx_d, sh;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W:0]     sum;
    always_comb begin
        sh   = {1'b0, idx_q[3:2], 1'b0} + {1'b0, idx_q[1:0], 1'b0};
        pp   = 16'(mult_p) << sh;
        sum  = {1'b0, acc_q} + {{(ACC_W-15){1'b0}}, prod_q};
        mult_a = (state_q == MUL) ? a_q[{idx_q[3:2], 1'b0} +: 2] : 2'b0;
        mult_b = (state_q == MUL) ? b_q[{idx_q[1:0], 1'b0} +: 2] : 2'b0;
    end
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        prod_d  = prod_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                acc_d = clr_acc ? '0 : acc_q;
                ovf_d = clr_acc ? 1'b0 : ovf_q;
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    prod_d  = '0;
                    idx_d   = '0;
                    state_d = MUL;
                end
            end
            MUL: begin
                prod_d  = prod_q + pp;
                idx_d   = idx_q + 4'd1;
                state_d = (idx_q == 4'd15) ? ACC : MUL;
            end
            ACC: begin
                acc_d   = sum[ACC_W-1:0];
                ovf_d   = ovf_q | sum[ACC_W];
                state_d = DONE;
            end
            default: begin
                acc_d   = clr_acc ? '0 : acc_q;
                ovf_d   = clr_acc ? 1'b0 : ovf_q;
                state_d = IDLE;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            prod_q  <= prod_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end
    assign busy    = (state_q == MUL) || (state_q == ACC);
    assign done    = (state_q == DONE);
    assign acc_out = acc_q;
    assign ovf     = ovf_q;
endmodule
